// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// default operand width and the sequencer state encoding.
package mult_div_ctrl_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Start/done handshake and operand/result bus between the control FSM (master)
// and the multiply/divide sequencer (slave).
interface mult_div_ctrl_if #(
  parameter int WIDTH = mult_div_ctrl_pkg::MDU_WIDTH
);

  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             mult_done;
  logic             div_done;
  logic             div_zero;
  logic             busy;

  modport master (
    output mult_start, div_start, op_a, op_b,
    input  hi_out, lo_out, mult_done, div_done, div_zero, busy
  );

  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output hi_out, lo_out, mult_done, div_done, div_zero, busy
  );

endinterface

// File: rtl/mult_div_ctrl_addsub.sv
// Single N-bit adder shared by the Booth and restoring-division steps;
// subtraction is done as a + ~b + 1 so only one carry chain exists.
module mdu_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);

  assign y = a + (b ^ {N{sub}}) + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/mult_div_ctrl.sv
// Radix-2 signed multiply (Booth) / divide (restoring) sequencer; one adder
// step per cycle, results land on hi/lo in S_FIX and done pulses in S_DONE.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  // acc doubles as the remainder, mq as the quotient, opd as mcand/divisor
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] mq_reg, mq_next;
  logic [WIDTH-1:0] opd_reg, opd_next;
  logic             qm1_reg, qm1_next;
  logic             is_div_reg, is_div_next;
  logic             zero_reg, zero_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;

  logic [WIDTH:0]   add_a, add_b, add_y;
  logic             add_sub;

  mdu_addsub #(.N(WIDTH + 1)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .y   (add_y)
  );

  always_comb begin
    add_a   = {acc_reg[WIDTH-1], acc_reg};
    add_b   = '0;
    add_sub = 1'b0;
    if (state_reg == S_DIV) begin
      add_a   = {acc_reg, mq_reg[WIDTH-1]};
      add_b   = {1'b0, opd_reg};
      add_sub = 1'b1;
    end else begin
      case ({mq_reg[0], qm1_reg})
        2'b01:   add_b = {opd_reg[WIDTH-1], opd_reg};
        2'b10: begin
          add_b   = {opd_reg[WIDTH-1], opd_reg};
          add_sub = 1'b1;
        end
        default: add_b = '0;
      endcase
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mq_next     = mq_reg;
    opd_next    = opd_reg;
    qm1_next    = qm1_reg;
    is_div_next = is_div_reg;
    zero_next   = zero_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.mult_start) begin
          acc_next    = '0;
          mq_next     = bus.op_b;
          qm1_next    = 1'b0;
          opd_next    = bus.op_a;
          cnt_next    = '0;
          is_div_next = 1'b0;
          zero_next   = 1'b0;
          state_next  = S_MULT;
        end else if (bus.div_start) begin
          is_div_next = 1'b1;
          if (bus.op_b != '0) begin
            // magnitudes are unsigned, so -2^(W-1) keeps its full value
            acc_next   = '0;
            mq_next    = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
            opd_next   = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
            cnt_next   = '0;
            neg_q_next = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            neg_r_next = bus.op_a[WIDTH-1];
            zero_next  = 1'b0;
            state_next = S_DIV;
          end else begin
            zero_next  = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_MULT: begin
        acc_next = add_y[WIDTH:1];
        mq_next  = {add_y[0], mq_reg[WIDTH-1:1]};
        qm1_next = mq_reg[0];
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) state_next = S_FIX;
      end
      S_DIV: begin
        // a negative trial restores the shifted remainder, which fits in W bits
        acc_next = add_y[WIDTH] ? {acc_reg[WIDTH-2:0], mq_reg[WIDTH-1]} : add_y[WIDTH-1:0];
        mq_next  = {mq_reg[WIDTH-2:0], ~add_y[WIDTH]};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) state_next = S_FIX;
      end
      S_FIX: begin
        if (is_div_reg) begin
          lo_next = neg_q_reg ? -mq_reg : mq_reg;
          hi_next = neg_r_reg ? -acc_reg : acc_reg;
        end else begin
          hi_next = acc_reg;
          lo_next = mq_reg;
        end
        state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mq_reg     <= '0;
      opd_reg    <= '0;
      qm1_reg    <= 1'b0;
      is_div_reg <= 1'b0;
      zero_reg   <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mq_reg     <= mq_next;
      opd_reg    <= opd_next;
      qm1_reg    <= qm1_next;
      is_div_reg <= is_div_next;
      zero_reg   <= zero_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  assign bus.hi_out    = hi_reg;
  assign bus.lo_out    = lo_reg;
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.mult_done = (state_reg == S_DONE) && !is_div_reg;
  assign bus.div_done  = (state_reg == S_DONE) && is_div_reg;
  assign bus.div_zero  = (state_reg == S_DONE) && is_div_reg && zero_reg;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench: stimulus pushes expected results computed with plain
// signed arithmetic; a negedge monitor pops and compares on every done pulse.
module tb_mult_div_ctrl;
  import mult_div_ctrl_pkg::*;

  localparam int W = MDU_WIDTH;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit           is_div;
    bit           zero;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           start_cyc;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc    = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  logic [W-1:0] edges [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (bus.mult_done || bus.div_done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {62'd0, bus.mult_done, bus.div_done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_kind", {61'd0, bus.mult_done, bus.div_done, bus.div_zero},
            {61'd0, !e.is_div, e.is_div, e.zero});
        chk("hi_out", {32'd0, bus.hi_out}, {32'd0, e.hi});
        chk("lo_out", {32'd0, bus.lo_out}, {32'd0, e.lo});
        chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
        $display("%s a=%h b=%h -> hi=%h lo=%h zero=%0d at cycle %0d",
                 e.is_div ? "div " : "mult", e.a, e.b, bus.hi_out, bus.lo_out, bus.div_zero, cyc);
      end
    end
  end

  // Call at a negedge; holds start for one cycle and records the expectation.
  task automatic issue(input bit ms, input bit ds, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    bus.mult_start = ms;
    bus.div_start  = ds;
    bus.op_a       = a;
    bus.op_b       = b;
    e.a = a;
    e.b = b;
    if (ms) begin
      p = sa * sb;
      e.is_div = 1'b0;
      e.zero   = 1'b0;
      e.hi     = p[2*W-1:W];
      e.lo     = p[W-1:0];
      e.lat    = W + 2;
    end else if (b == '0) begin
      e.is_div = 1'b1;
      e.zero   = 1'b1;
      e.hi     = model_hi;
      e.lo     = model_lo;
      e.lat    = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.is_div = 1'b1;
      e.zero   = 1'b0;
      e.hi     = r[W-1:0];
      e.lo     = q[W-1:0];
      e.lat    = W + 2;
    end
    model_hi    = e.hi;
    model_lo    = e.lo;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
  endtask

  task automatic finish_op(input int exp_busy, input string tag);
    int bc = 0;
    while (bus.busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
  endtask

  task automatic run(input bit ms, input bit ds, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    issue(ms, ds, a, b);
    finish_op((ms || b != '0) ? W + 2 : 1, tag);
  endtask

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    bit           rk;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    chk("reset_flags", {60'd0, bus.busy, bus.mult_done, bus.div_done, bus.div_zero}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run(1, 0, 32'd6, 32'd7, "mult_6x7");
    run(1, 0, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
    run(1, 0, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
    run(0, 1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run(0, 1, 32'd5, 32'd0, "div_5_0");
    run(1, 1, 32'd9, 32'hFFFF_FFFE, "both_starts");

    // div_start in cycle 10 of a multiply must be ignored
    issue(1, 0, 32'd1234, 32'hFFFF_FF00);
    repeat (9) @(negedge clk);
    bus.div_start = 1'b1;
    bus.op_a      = 32'd100;
    bus.op_b      = 32'd3;
    @(negedge clk);
    bus.div_start = 1'b0;
    finish_op(W + 2 - 10, "mult_mid_div");

    // reset in cycle 15 of a divide aborts it with no done pulse
    issue(0, 1, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    chk("abort_flags", {60'd0, bus.busy, bus.mult_done, bus.div_done, bus.div_zero}, 64'd0);
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    run(1, 0, 32'd2, 32'd3, "mult_after_reset");

    for (int i = 0; i < 40; i++) begin
      rk = 1'($urandom_range(0, 1));
      ra = pick();
      rb = pick();
      if (rk && $urandom_range(0, 7) == 0) rb = '0;
      run(!rk, rk, ra, rb, "random");
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
